evo_nor_array_eval: RTL and testbench
=====================================

Name: evo_nor_array_eval

Overview:
- Parametrised, reconfigurable array of 2-input NOR cells for evolved-circuit experiments.
- Each gate's two inputs and the array output are chosen by a loaded genome, so feedback loops are allowed.
- A built-in evaluator sweeps every input vector, waits for the network to settle, and double-samples the output to detect oscillation.
- Reports a fitness score against a target truth table. Sits between the evolution controller (genome and target source) and the result collector.

Parameters:
- NUM_INPUTS, 2, primary circuit inputs; the sweep covers 2^NUM_INPUTS vectors.
- NUM_GATES, 4, number of NOR cells.
- SEL_W, 3, selector width; must satisfy 2^SEL_W >= NUM_INPUTS+NUM_GATES.
- SETTLE_CYCLES, 4, wait cycles between applying a vector and the first sample; minimum 1.
- ASYNC, 0, gate mode. 1 = each NOR output passes through an LCELL keep-buffer (true combinational loops, hardware only). 0 = each NOR output is registered on clk (simulation and synchronous model).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin an evaluation; sampled only in IDLE
- genome  in  (2*NUM_GATES+1)*SEL_W  configuration, latched on accepted start
- target  in  2^NUM_INPUTS  expected output, bit v is the expected output for vector v; latched on start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the result is valid
- fitness  out  NUM_INPUTS+1  count of stable, matching vectors
- unstable  out  NUM_INPUTS+1  count of vectors whose two samples differed
- circ_out  out  1  live array output, for probing

Behaviour:
- Source index s: s<NUM_INPUTS selects in_vec[s]. s<NUM_INPUTS+NUM_GATES selects w[s-NUM_INPUTS]. Larger values give constant 0.
- Genome packing: gate g input A = genome[2g*SEL_W +: SEL_W], input B = genome[(2g+1)*SEL_W +: SEL_W]. Output select = genome[2*NUM_GATES*SEL_W +: SEL_W]. circ_out = selected source.
- Gate g computes w[g] = NOR(srcA, srcB). When ASYNC=0, w[g] is a register updated every clk, cleared by reset and on accepted start.
- Reset: state IDLE; busy=0, done=0, fitness=0, unstable=0; genome, target, in_vec and the vector counter all cleared to 0.
- FSM states: IDLE, APPLY, SETTLE, SAMPLE1, SAMPLE2, DONE.
- IDLE: start=1 latches genome and target, clears fitness, unstable, the vector counter and (ASYNC=0) the gate registers, then goes to APPLY.
- APPLY (1 cycle): in_vec <= vector counter; then SETTLE.
- SETTLE: lasts exactly SETTLE_CYCLES cycles; then SAMPLE1.
- SAMPLE1 (1 cycle): capture circ_out into s1.
- SAMPLE2 (1 cycle): compare circ_out with s1.
  - If they differ: unstable+1; the vector does not score.
  - Else if s1 == target[vector]: fitness+1.
  - Then: if this is the last vector, go to DONE; else vector counter+1 and go to APPLY.
- DONE (1 cycle): done=1, busy=1; then IDLE.
- fitness and unstable hold their values until the next accepted start.
- Latency: start accepted in cycle T gives done in cycle T+1+2^NUM_INPUTS*(SETTLE_CYCLES+3).
- start while busy is ignored and has no side effect. start and reset together: reset wins.
- Reset mid-sweep: IDLE on the next cycle, all outputs 0, no done pulse.
- Vector counter width is NUM_INPUTS. The last vector is all-ones; the counter never wraps within a sweep.
- Invariant: fitness+unstable <= 2^NUM_INPUTS, so NUM_INPUTS+1 bits never overflow.

Test Plan:
- Defaults, ASYNC=0. Gate0 = NOR(in0,in1) (A=0, B=1), output select 2, other gates selector 6, target 4'b0001, start -> done at T+29, fitness=4, unstable=0.
- Same genome, target 4'b1110 -> fitness=0, unstable=0.
- Oscillator: gate0 A=2 (self), B=6 (const 0), output select 2, any target -> w0 toggles every cycle, unstable=4, fitness=0.
- Output select 7 (const 0), target 4'b0101 -> fitness=2, unstable=0. fitness still 2 twenty cycles after done.
- start pulsed again at T+5 with a different target -> ignored: result and done timing identical to the single-start run.
- rst_n=0 for one cycle at T+10 -> next cycle busy=0, fitness=0, unstable=0, and done never pulses. A fresh start then completes normally at T'+29.

Source files
------------

// File: rtl/evo_nor_array_eval.sv
`default_nettype none
// ============================================================================
// Module   : evo_nor_array_eval
// Brief    : Genome-configured 2-input NOR array with built-in truth-table
//            sweep, settle wait, double-sample oscillation check and fitness.
// Revision : 1.0
// ============================================================================
module evo_nor_array_eval #(
  parameter int NUM_INPUTS    = 2,
  parameter int NUM_GATES     = 4,
  parameter int SEL_W         = 3,
  parameter int SETTLE_CYCLES = 4,
  parameter int ASYNC         = 0
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start_i,
  input  logic [(2*NUM_GATES+1)*SEL_W-1:0]      genome_i,
  input  logic [2**NUM_INPUTS-1:0]              target_i,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic [NUM_INPUTS:0]                   fitness_o,
  output logic [NUM_INPUTS:0]                   unstable_o,
  output logic                                  circ_out_o
);

  localparam int GENOME_W = (2*NUM_GATES+1)*SEL_W;
  localparam int NUM_SRC  = 2**SEL_W;
  localparam int NUM_VEC  = 2**NUM_INPUTS;
  localparam int CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_APPLY   = 3'd1,
    S_SETTLE  = 3'd2,
    S_SAMPLE1 = 3'd3,
    S_SAMPLE2 = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [GENOME_W-1:0]     genome_q, genome_d;
  logic [NUM_VEC-1:0]      target_q, target_d;
  logic [NUM_INPUTS-1:0]   in_vec_q, in_vec_d;
  logic [NUM_INPUTS-1:0]   vec_q, vec_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    s1_q, s1_d;
  logic [NUM_INPUTS:0]     fitness_q, fitness_d;
  logic [NUM_INPUTS:0]     unstable_q, unstable_d;

  logic [NUM_SRC-1:0]      src_vec;
  logic [NUM_GATES-1:0]    nor_out;
  logic [NUM_GATES-1:0]    gate_out;
  logic [SEL_W-1:0]        out_sel;
  logic                    start_accept;

  assign start_accept = (state_q == S_IDLE) && start_i;

  // Selector values beyond the inputs and gates read the zero padding.
  always_comb begin
    src_vec = '0;
    src_vec[NUM_INPUTS-1:0]         = in_vec_q;
    src_vec[NUM_INPUTS +: NUM_GATES] = gate_out;
  end

  for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
    assign nor_out[g] = ~(src_vec[genome_q[2*g*SEL_W +: SEL_W]] |
                          src_vec[genome_q[(2*g+1)*SEL_W +: SEL_W]]);
  end

  if (ASYNC != 0) begin : g_async
    assign gate_out = nor_out;
  end else begin : g_sync
    logic [NUM_GATES-1:0] w_q;
    always_ff @(posedge clk) begin
      if (!rst_n || start_accept) begin
        w_q <= '0;
      end else begin
        w_q <= nor_out;
      end
    end
    assign gate_out = w_q;
  end

  assign out_sel    = genome_q[2*NUM_GATES*SEL_W +: SEL_W];
  assign circ_out_o = src_vec[out_sel];

  always_comb begin
    state_d    = state_q;
    genome_d   = genome_q;
    target_d   = target_q;
    in_vec_d   = in_vec_q;
    vec_d      = vec_q;
    cnt_d      = cnt_q;
    s1_d       = s1_q;
    fitness_d  = fitness_q;
    unstable_d = unstable_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          genome_d   = genome_i;
          target_d   = target_i;
          fitness_d  = '0;
          unstable_d = '0;
          vec_d      = '0;
          state_d    = S_APPLY;
        end
      end
      S_APPLY: begin
        in_vec_d = vec_q;
        cnt_d    = '0;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES-1)) begin
          state_d = S_SAMPLE1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SAMPLE1: begin
        s1_d    = circ_out_o;
        state_d = S_SAMPLE2;
      end
      S_SAMPLE2: begin
        // An output that moved between the two samples never scores.
        if (circ_out_o != s1_q) begin
          unstable_d = unstable_q + (NUM_INPUTS+1)'(1);
        end else if (s1_q == target_q[vec_q]) begin
          fitness_d = fitness_q + (NUM_INPUTS+1)'(1);
        end
        if (vec_q == {NUM_INPUTS{1'b1}}) begin
          state_d = S_DONE;
        end else begin
          vec_d   = vec_q + NUM_INPUTS'(1);
          state_d = S_APPLY;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      genome_q   <= '0;
      target_q   <= '0;
      in_vec_q   <= '0;
      vec_q      <= '0;
      cnt_q      <= '0;
      s1_q       <= 1'b0;
      fitness_q  <= '0;
      unstable_q <= '0;
    end else begin
      state_q    <= state_d;
      genome_q   <= genome_d;
      target_q   <= target_d;
      in_vec_q   <= in_vec_d;
      vec_q      <= vec_d;
      cnt_q      <= cnt_d;
      s1_q       <= s1_d;
      fitness_q  <= fitness_d;
      unstable_q <= unstable_d;
    end
  end

  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_DONE);
  assign fitness_o  = fitness_q;
  assign unstable_o = unstable_q;

endmodule
`default_nettype wire

// File: tb/tb_evo_nor_array_eval.sv
`default_nettype none
// ============================================================================
// Module   : tb_evo_nor_array_eval
// Brief    : Randomized bench for evo_nor_array_eval against a cycle-indexed
//            behavioural model of the evaluation sweep.
// Revision : 1.0
// ============================================================================
module tb_evo_nor_array_eval;

  localparam int NI  = 2;
  localparam int NG  = 4;
  localparam int SW  = 3;
  localparam int SC  = 4;
  localparam int GW  = (2*NG+1)*SW;
  localparam int NV  = 1 << NI;
  localparam int PER = SC + 3;
  localparam int LAT = 1 + NV*PER;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [GW-1:0] genome = '0;
  logic [NV-1:0] target = '0;
  logic          busy, done, circ_out;
  logic [NI:0]   fitness, unstable;

  always #5 clk = ~clk;

  evo_nor_array_eval #(
    .NUM_INPUTS(NI), .NUM_GATES(NG), .SEL_W(SW), .SETTLE_CYCLES(SC), .ASYNC(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .genome_i(genome),
    .target_i(target), .busy_o(busy), .done_o(done), .fitness_o(fitness),
    .unstable_o(unstable), .circ_out_o(circ_out)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int selof(input logic [GW-1:0] gn, input int idx);
    return int'(gn[idx*SW +: SW]);
  endfunction

  function automatic bit msrc(input int s, input logic [NI-1:0] inv, input logic [NG-1:0] w);
    if (s < NI) return inv[s];
    if (s < NI + NG) return w[s-NI];
    return 1'b0;
  endfunction

  // Model: position in the sweep is derived from cycles since acceptance.
  bit            m_busy = 0;
  int            m_cyc = 0;
  logic [GW-1:0] m_gen = '0;
  logic [NV-1:0] m_tgt = '0;
  logic [NI-1:0] m_in = '0;
  logic [NG-1:0] m_w = '0;
  logic [NG-1:0] nw;
  bit            m_s1 = 0, cur;
  int            m_fit = 0, m_uns = 0;
  int            ph, vv;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    cur = msrc(selof(m_gen, 2*NG), m_in, m_w);
    for (int g = 0; g < NG; g++)
      nw[g] = ~(msrc(selof(m_gen, 2*g), m_in, m_w) | msrc(selof(m_gen, 2*g+1), m_in, m_w));
    if (!rst_n) begin
      m_busy = 0; m_cyc = 0; m_gen = '0; m_tgt = '0; m_in = '0;
      m_w = '0; m_s1 = 0; m_fit = 0; m_uns = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_gen = genome; m_tgt = target; m_fit = 0; m_uns = 0;
        m_w = '0; m_busy = 1; m_cyc = 1;
      end else begin
        m_w = nw;
      end
    end else begin
      m_w = nw;
      if (m_cyc == LAT) begin
        m_busy = 0;
      end else begin
        ph = (m_cyc - 1) % PER;
        vv = (m_cyc - 1) / PER;
        if (ph == 0) m_in = NI'(vv);
        else if (ph == SC + 1) m_s1 = cur;
        else if (ph == SC + 2) begin
          if (cur != m_s1) m_uns++;
          else if (m_s1 == m_tgt[vv]) m_fit++;
        end
      end
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_busy && m_cyc == LAT));
      chk("fitness", 32'(fitness), 32'(m_fit));
      chk("unstable", 32'(unstable), 32'(m_uns));
      chk("circ_out", 32'(circ_out), 32'(msrc(selof(m_gen, 2*NG), m_in, m_w)));
    end
  end

  function automatic logic [GW-1:0] mkgen(input int a0, input int b0, input int osel);
    logic [GW-1:0] gn;
    gn = '0;
    for (int g = 0; g < NG; g++) begin
      gn[2*g*SW +: SW]     = SW'((g == 0) ? a0 : 6);
      gn[(2*g+1)*SW +: SW] = SW'((g == 0) ? b0 : 6);
    end
    gn[2*NG*SW +: SW] = SW'(osel);
    return gn;
  endfunction

  task automatic run(input logic [GW-1:0] gen, input logic [NV-1:0] tgt,
                     input int extra, input int rst_at,
                     output int lat, output int fit, output int uns, output bit got);
    int t0;
    lat = -1; fit = -1; uns = -1; got = 0;
    @(negedge clk);
    genome = gen; target = tgt; start = 1'b1; t0 = cyc;
    for (int k = 0; k < LAT + 20; k++) begin
      @(negedge clk);
      start = 1'b0; rst_n = 1'b1; genome = gen; target = tgt;
      if (done) begin
        got = 1; lat = cyc - t0; fit = int'(fitness); uns = int'(unstable);
        break;
      end
      if (rst_at >= 0 && cyc - t0 == rst_at + 1) begin
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_fitness", 32'(fitness), 0);
        chk("post_rst_unstable", 32'(unstable), 0);
      end
      if (cyc - t0 == extra) begin
        start = 1'b1; genome = ~gen; target = ~tgt;
      end
      if (cyc - t0 == rst_at) rst_n = 1'b0;
    end
  endtask

  initial begin
    int lat, fit, uns;
    bit got;
    logic [63:0] r;
    int extra, rat;

    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_fitness", 32'(fitness), 0);
    chk("reset_unstable", 32'(unstable), 0);
    rst_n = 1'b1;

    run(mkgen(0, 1, 2), 4'b0001, -1, -1, lat, fit, uns, got);
    chk("nor_lat", 32'(lat), LAT);
    chk("nor_fit", 32'(fit), 4);
    chk("nor_uns", 32'(uns), 0);

    run(mkgen(0, 1, 2), 4'b1110, -1, -1, lat, fit, uns, got);
    chk("inv_fit", 32'(fit), 0);
    chk("inv_uns", 32'(uns), 0);

    run(mkgen(2, 6, 2), 4'b1010, -1, -1, lat, fit, uns, got);
    chk("osc_fit", 32'(fit), 0);
    chk("osc_uns", 32'(uns), 4);

    run(mkgen(0, 1, 7), 4'b0101, -1, -1, lat, fit, uns, got);
    chk("const_fit", 32'(fit), 2);
    chk("const_uns", 32'(uns), 0);
    repeat (20) @(negedge clk);
    chk("const_hold", 32'(fitness), 2);

    run(mkgen(0, 1, 2), 4'b0001, 5, -1, lat, fit, uns, got);
    chk("restart_lat", 32'(lat), LAT);
    chk("restart_fit", 32'(fit), 4);

    run(mkgen(0, 1, 2), 4'b0001, -1, 10, lat, fit, uns, got);
    chk("rst_no_done", 32'(got), 0);

    run(mkgen(0, 1, 2), 4'b0001, -1, -1, lat, fit, uns, got);
    chk("fresh_lat", 32'(lat), LAT);
    chk("fresh_fit", 32'(fit), 4);

    for (int i = 0; i < 30; i++) begin
      r = {$urandom, $urandom};
      extra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, LAT - 2)) : -1;
      rat   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, LAT - 2)) : -1;
      run(r[GW-1:0], NV'($urandom), extra, rat, lat, fit, uns, got);
      if (rat >= 0) begin
        chk("rand_rst_no_done", 32'(got), 0);
      end else begin
        chk("rand_lat", 32'(lat), LAT);
        chk("rand_bound", 32'(fit + uns <= NV), 1);
      end
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
